// File: rtl/unsigned_divide.sv
// Sequential restoring unsigned divider: one quotient bit per cycle, MSB first,
// with valid/ready handshakes on the operand and result sides.
module unsigned_divide #(
  parameter int N_WIDTH = 10,
  parameter int D_WIDTH = 5
) (
  input  logic               clock0,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_WIDTH-1:0] dividend,
  input  logic [D_WIDTH-1:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] quotient,
  output logic [D_WIDTH-1:0] remainder,
  output logic               div_by_zero
);

  localparam int CNT_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_reg, state_next;
  logic [N_WIDTH-1:0] dvd_reg, dvd_next;
  logic [D_WIDTH-1:0] dsr_reg, dsr_next;
  logic [D_WIDTH:0]   partial_reg, partial_next;
  logic [N_WIDTH-1:0] quot_work_reg, quot_work_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [N_WIDTH-1:0] quotient_reg, quotient_next;
  logic [D_WIDTH-1:0] remainder_reg, remainder_next;
  logic               dbz_reg, dbz_next;

  // Trial subtraction of the divisor from the shifted partial remainder.
  logic [D_WIDTH+1:0] shifted;
  logic [D_WIDTH:0]   divisor_ext;
  logic [D_WIDTH:0]   diff;
  logic [D_WIDTH+1:0] borrow;
  logic               fits;
  logic [D_WIDTH:0]   partial_step;
  logic [N_WIDTH-1:0] quot_step;

  assign shifted     = {partial_reg, dvd_reg[N_WIDTH-1]};
  assign divisor_ext = {1'b0, dsr_reg};
  assign borrow[0]   = 1'b0;

  generate
    for (genvar gi = 0; gi <= D_WIDTH; gi++) begin : g_sub
      assign diff[gi]     = shifted[gi] ^ divisor_ext[gi] ^ borrow[gi];
      assign borrow[gi+1] = (~shifted[gi] & divisor_ext[gi]) |
                            (~(shifted[gi] ^ divisor_ext[gi]) & borrow[gi]);
    end
  endgenerate

  // A set top bit means the shifted value already exceeds any D_WIDTH divisor.
  assign fits         = shifted[D_WIDTH+1] | ~borrow[D_WIDTH+1];
  assign partial_step = fits ? diff : shifted[D_WIDTH:0];
  assign quot_step    = (quot_work_reg << 1) | N_WIDTH'(fits);

  always_ff @(posedge clock0) begin
    if (reset) begin
      state_reg     <= IDLE;
      dvd_reg       <= '0;
      dsr_reg       <= '0;
      partial_reg   <= '0;
      quot_work_reg <= '0;
      count_reg     <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      dbz_reg       <= 1'b0;
    end else begin
      state_reg     <= state_next;
      dvd_reg       <= dvd_next;
      dsr_reg       <= dsr_next;
      partial_reg   <= partial_next;
      quot_work_reg <= quot_work_next;
      count_reg     <= count_next;
      quotient_reg  <= quotient_next;
      remainder_reg <= remainder_next;
      dbz_reg       <= dbz_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    dvd_next       = dvd_reg;
    dsr_next       = dsr_reg;
    partial_next   = partial_reg;
    quot_work_next = quot_work_reg;
    count_next     = count_reg;
    quotient_next  = quotient_reg;
    remainder_next = remainder_reg;
    dbz_next       = dbz_reg;

    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          dvd_next = dividend;
          dsr_next = divisor;
          if (divisor == '0) begin
            quotient_next  = '1;
            remainder_next = '0;
            dbz_next       = 1'b1;
            state_next     = DONE;
          end else begin
            partial_next   = '0;
            quot_work_next = '0;
            count_next     = CNT_W'(N_WIDTH - 1);
            state_next     = CALC;
          end
        end
      end
      CALC: begin
        dvd_next       = dvd_reg << 1;
        partial_next   = partial_step;
        quot_work_next = quot_step;
        if (count_reg == '0) begin
          quotient_next  = quot_step;
          remainder_next = partial_step[D_WIDTH-1:0];
          dbz_next       = 1'b0;
          state_next     = DONE;
        end else begin
          count_next = count_reg - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign in_ready    = (state_reg == IDLE);
  assign out_valid   = (state_reg == DONE);
  assign quotient    = quotient_reg;
  assign remainder   = remainder_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_unsigned_divide.sv
// Directed and random bench for unsigned_divide; expected results travel
// through a scoreboard queue from the drive point to the result point.
module tb_unsigned_divide;

  logic       clock0 = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] dividend = '0;
  logic [4:0] divisor = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [9:0] quotient;
  logic [4:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [9:0] q;
    logic [4:0] r;
    logic       z;
    int         lat;
  } exp_t;

  exp_t sb[$];

  unsigned_divide #(.N_WIDTH(10), .D_WIDTH(5)) dut (
    .clock0     (clock0),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clock0 = ~clock0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Entered and left #1 after a rising edge; returns with the result presented.
  task automatic run_op(input logic [9:0] a, input logic [4:0] b,
                        input logic [9:0] eq, input logic [4:0] er,
                        input logic ez, input int elat);
    exp_t e;
    int   lat;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    sb.push_back('{q: eq, r: er, z: ez, lat: elat});
    check("in_ready_before_accept", in_ready, 1);
    @(posedge clock0);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin
      @(posedge clock0);
      #1;
      lat++;
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("latency", lat, e.lat);
      check("quotient", quotient, e.q);
      check("remainder", remainder, e.r);
      check("div_by_zero", div_by_zero, e.z);
      check("in_ready_in_done", in_ready, 0);
    end
    $display("op %0d/%0d -> q=%0d r=%0d z=%0d lat=%0d", a, b, quotient, remainder,
             div_by_zero, lat);
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clock0);
    #1;
    check("release_out_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    int unsigned a, b;

    // Reset state
    repeat (3) @(posedge clock0);
    #1;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_quotient", quotient, 0);
    check("reset_remainder", remainder, 0);
    check("reset_dbz", div_by_zero, 0);
    reset = 1'b0;
    @(posedge clock0);
    #1;

    // Basic and divide-by-zero
    run_op(10'd1000, 5'd31, 10'd32, 5'd8, 1'b0, 11);
    finish_op();
    run_op(10'd5, 5'd0, 10'd1023, 5'd0, 1'b1, 1);
    finish_op();

    // Edge values
    run_op(10'd1023, 5'd1, 10'd1023, 5'd0, 1'b0, 11);
    finish_op();
    run_op(10'd0, 5'd7, 10'd0, 5'd0, 1'b0, 11);
    finish_op();
    run_op(10'd20, 5'd31, 10'd0, 5'd20, 1'b0, 11);
    finish_op();
    run_op(10'd961, 5'd31, 10'd31, 5'd0, 1'b0, 11);
    finish_op();

    // Backpressure: results held, new operands ignored while stalled
    out_ready = 1'b0;
    run_op(10'd100, 5'd7, 10'd14, 5'd2, 1'b0, 11);
    for (int i = 0; i < 5; i++) begin
      dividend = 10'd3;
      divisor  = 5'd1;
      in_valid = 1'b1;
      @(posedge clock0);
      #1;
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_quotient", quotient, 14);
      check("stall_remainder", remainder, 2);
    end
    in_valid = 1'b0;
    finish_op();

    // Reset during the 4th CALC cycle discards the operation
    dividend = 10'd500;
    divisor  = 5'd3;
    in_valid = 1'b1;
    @(posedge clock0);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clock0);
    #1;
    reset = 1'b1;
    @(posedge clock0);
    #1;
    reset = 1'b0;
    check("midreset_in_ready", in_ready, 1);
    check("midreset_out_valid", out_valid, 0);
    check("midreset_quotient", quotient, 0);
    check("midreset_remainder", remainder, 0);
    check("midreset_dbz", div_by_zero, 0);
    run_op(10'd77, 5'd7, 10'd11, 5'd0, 1'b0, 11);
    finish_op();

    // Random products: quotient recovers the first factor exactly
    for (int i = 0; i < 100; i++) begin
      a = $urandom_range(31, 1);
      b = $urandom_range(31, 1);
      run_op(10'(a * b), 5'(b), 10'(a), 5'd0, 1'b0, 11);
      finish_op();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
